// File: rtl/pipe_ctrl.sv
// Pipeline controller for the 5-stage MIPS core: merges stage stall requests, sequences
// exception/ERET redirects as freeze-then-flush, and keeps stall/flush statistics and a watchdog.
module pipe_ctrl #(
    parameter logic [31:0] EXC_VECTOR    = 32'h0000_0020,
    parameter logic [15:0] STALL_TIMEOUT = 16'd1024,
    parameter int unsigned CNT_W         = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallreq_if,
    input  logic             stallreq_id,
    input  logic             stallreq_ex,
    input  logic             stallreq_mem,
    input  logic [31:0]      excepttype_i,
    input  logic [31:0]      cp0_epc_i,
    output logic [5:0]       stall,
    output logic             flush,
    output logic [31:0]      new_pc,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [15:0]      flush_count,
    output logic             stall_timeout
);

    localparam logic [31:0] ExcEret = 32'h0000_000e;

    localparam logic [5:0] StallNone   = 6'b000000;
    localparam logic [5:0] StallIf     = 6'b000011;
    localparam logic [5:0] StallId     = 6'b000111;
    localparam logic [5:0] StallEx     = 6'b001111;
    localparam logic [5:0] StallMem    = 6'b011111;
    localparam logic [5:0] StallFreeze = 6'b111111;

    typedef enum logic [1:0] {
        StIdle,
        StWaitMem,
        StFlush
    } state_e;

    state_e           state_q, state_d;
    logic [31:0]      code_q, code_d;
    logic [31:0]      new_pc_q, new_pc_d;
    logic             flush_q, flush_d;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [15:0]      flush_count_q, flush_count_d;
    logic [15:0]      run_cnt_q, run_cnt_d;
    logic             timeout_q, timeout_d;
    logic             exc_pending;

    assign exc_pending = (excepttype_i != 32'h0);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; the redirect target is chosen only once MEM is no longer stalled
    always_comb begin
        state_d  = state_q;
        code_d   = code_q;
        new_pc_d = new_pc_q;
        unique case (state_q)
            StIdle: begin
                if (exc_pending) begin
                    if (stallreq_mem) begin
                        state_d = StWaitMem;
                        code_d  = excepttype_i;
                    end else begin
                        state_d  = StFlush;
                        new_pc_d = (excepttype_i == ExcEret) ? cp0_epc_i : EXC_VECTOR;
                    end
                end
            end
            StWaitMem: begin
                if (!stallreq_mem) begin
                    state_d  = StFlush;
                    new_pc_d = (code_q == ExcEret) ? cp0_epc_i : EXC_VECTOR;
                end
            end
            StFlush: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Stall vector output
    always_comb begin
        stall = StallNone;
        if (!rst) begin
            unique case (state_q)
                StIdle: begin
                    if (exc_pending) begin
                        stall = stallreq_mem ? StallMem : StallFreeze;
                    end else if (stallreq_mem) begin
                        stall = StallMem;
                    end else if (stallreq_ex) begin
                        stall = StallEx;
                    end else if (stallreq_id) begin
                        stall = StallId;
                    end else if (stallreq_if) begin
                        stall = StallIf;
                    end
                end
                StWaitMem: begin
                    stall = stallreq_mem ? StallMem : StallFreeze;
                end
                StFlush: begin
                    stall = StallNone;
                end
                default: begin
                    stall = StallNone;
                end
            endcase
        end
    end

    // Statistics and watchdog
    always_comb begin
        flush_d        = (state_d == StFlush);
        stall_cycles_d = stall_cycles_q + CNT_W'(stall[0]);
        flush_count_d  = flush_count_q + 16'((state_q == StFlush) ? 1 : 0);
        if (!stall[0]) begin
            run_cnt_d = 16'h0;
        end else if (run_cnt_q >= STALL_TIMEOUT) begin
            run_cnt_d = STALL_TIMEOUT;
        end else begin
            run_cnt_d = run_cnt_q + 16'h1;
        end
        timeout_d = timeout_q | (run_cnt_d == STALL_TIMEOUT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            code_q         <= 32'h0;
            new_pc_q       <= 32'h0;
            flush_q        <= 1'b0;
            stall_cycles_q <= '0;
            flush_count_q  <= 16'h0;
            run_cnt_q      <= 16'h0;
            timeout_q      <= 1'b0;
        end else begin
            code_q         <= code_d;
            new_pc_q       <= new_pc_d;
            flush_q        <= flush_d;
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
            run_cnt_q      <= run_cnt_d;
            timeout_q      <= timeout_d;
        end
    end

    assign flush         = flush_q;
    assign new_pc        = new_pc_q;
    assign stall_cycles  = stall_cycles_q;
    assign flush_count   = flush_count_q;
    assign stall_timeout = timeout_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl: stall merging, freeze-then-flush redirects,
// statistics, watchdog and asynchronous reset.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
    logic [31:0] excepttype_i, cp0_epc_i;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic [31:0] stall_cycles;
    logic [15:0] flush_count;
    logic        stall_timeout;

    int n_pass  = 0;
    int n_total = 0;

    pipe_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .stallreq_if  (stallreq_if),
        .stallreq_id  (stallreq_id),
        .stallreq_ex  (stallreq_ex),
        .stallreq_mem (stallreq_mem),
        .excepttype_i (excepttype_i),
        .cp0_epc_i    (cp0_epc_i),
        .stall        (stall),
        .flush        (flush),
        .new_pc       (new_pc),
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count),
        .stall_timeout(stall_timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        {stallreq_if, stallreq_id, stallreq_ex, stallreq_mem} = 4'b1111;
        excepttype_i = 32'h8;
        cp0_epc_i    = 32'h0;
        #3;
        n_total++; if (stall !== 6'b000000) $display("FAIL rst_stall got=%b exp=000000", stall); else n_pass++;
        n_total++; if (flush !== 1'b0) $display("FAIL rst_flush got=%b exp=0", flush); else n_pass++;
        n_total++; if (new_pc !== 32'h0) $display("FAIL rst_new_pc got=%h exp=0", new_pc); else n_pass++;
        n_total++; if (stall_cycles !== 32'h0) $display("FAIL rst_cycles got=%0d exp=0", stall_cycles); else n_pass++;
        n_total++; if (flush_count !== 16'h0) $display("FAIL rst_fcount got=%0d exp=0", flush_count); else n_pass++;
        n_total++; if (stall_timeout !== 1'b0) $display("FAIL rst_timeout got=%b exp=0", stall_timeout); else n_pass++;
        tick();
        {stallreq_if, stallreq_id, stallreq_ex, stallreq_mem} = 4'b0000;
        excepttype_i = 32'h0;
        rst = 1'b0;
        #1;
        n_total++; if (stall !== 6'b000000) $display("FAIL idle_stall got=%b exp=000000", stall); else n_pass++;
    endtask

    task automatic test_requests();
        // {if,id,ex,mem} -> stall
        logic [3:0] req [5] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0101};
        logic [5:0] exp [5] = '{6'b000011, 6'b000111, 6'b001111, 6'b011111, 6'b011111};
        for (int i = 0; i < 5; i++) begin
            {stallreq_if, stallreq_id, stallreq_ex, stallreq_mem} = req[i];
            #1;
            n_total++; if (stall !== exp[i]) $display("FAIL req%0d_stall got=%b exp=%b", i, stall, exp[i]); else n_pass++;
            n_total++; if (flush !== 1'b0) $display("FAIL req%0d_flush got=%b exp=0", i, flush); else n_pass++;
            tick();
        end
        {stallreq_if, stallreq_id, stallreq_ex, stallreq_mem} = 4'b0000;
        #1;
        n_total++; if (stall_cycles !== 32'd5) $display("FAIL req_cycles got=%0d exp=5", stall_cycles); else n_pass++;
    endtask

    task automatic test_exception();
        excepttype_i = 32'h8;
        #1;
        n_total++; if (stall !== 6'b111111) $display("FAIL exc_freeze got=%b exp=111111", stall); else n_pass++;
        n_total++; if (flush !== 1'b0) $display("FAIL exc_noflush got=%b exp=0", flush); else n_pass++;
        tick();
        excepttype_i = 32'h0;
        stallreq_mem = 1'b1;
        #1;
        n_total++; if (flush !== 1'b1) $display("FAIL exc_flush got=%b exp=1", flush); else n_pass++;
        n_total++; if (new_pc !== 32'h20) $display("FAIL exc_new_pc got=%h exp=00000020", new_pc); else n_pass++;
        n_total++; if (stall !== 6'b000000) $display("FAIL exc_flush_stall got=%b exp=000000", stall); else n_pass++;
        stallreq_mem = 1'b0;
        tick();
        n_total++; if (flush !== 1'b0) $display("FAIL exc_flush_end got=%b exp=0", flush); else n_pass++;
        n_total++; if (flush_count !== 16'd1) $display("FAIL exc_fcount got=%0d exp=1", flush_count); else n_pass++;
        n_total++; if (stall_cycles !== 32'd6) $display("FAIL exc_cycles got=%0d exp=6", stall_cycles); else n_pass++;
    endtask

    task automatic test_eret();
        excepttype_i = 32'he;
        cp0_epc_i    = 32'hBFC0_0100;
        #1;
        n_total++; if (stall !== 6'b111111) $display("FAIL eret_freeze got=%b exp=111111", stall); else n_pass++;
        tick();
        excepttype_i = 32'h0;
        cp0_epc_i    = 32'h1234_5678;
        #1;
        n_total++; if (flush !== 1'b1) $display("FAIL eret_flush got=%b exp=1", flush); else n_pass++;
        n_total++; if (new_pc !== 32'hBFC0_0100) $display("FAIL eret_new_pc got=%h exp=bfc00100", new_pc); else n_pass++;
        tick();
        tick();
        n_total++; if (flush !== 1'b0) $display("FAIL eret_flush_end got=%b exp=0", flush); else n_pass++;
        n_total++; if (new_pc !== 32'hBFC0_0100) $display("FAIL eret_hold got=%h exp=bfc00100", new_pc); else n_pass++;
        n_total++; if (flush_count !== 16'd2) $display("FAIL eret_fcount got=%0d exp=2", flush_count); else n_pass++;
        n_total++; if (stall_cycles !== 32'd7) $display("FAIL eret_cycles got=%0d exp=7", stall_cycles); else n_pass++;
    endtask

    task automatic test_wait_mem();
        excepttype_i = 32'hc;
        stallreq_mem = 1'b1;
        #1;
        n_total++; if (stall !== 6'b011111) $display("FAIL wm_stall0 got=%b exp=011111", stall); else n_pass++;
        tick();
        excepttype_i = 32'h0;
        stallreq_id  = 1'b1;
        for (int i = 1; i < 3; i++) begin
            #1;
            n_total++; if (stall !== 6'b011111) $display("FAIL wm_stall%0d got=%b exp=011111", i, stall); else n_pass++;
            n_total++; if (flush !== 1'b0) $display("FAIL wm_flush%0d got=%b exp=0", i, flush); else n_pass++;
            tick();
        end
        stallreq_mem = 1'b0;
        stallreq_id  = 1'b0;
        cp0_epc_i    = 32'hBFC0_0200;
        #1;
        n_total++; if (stall !== 6'b111111) $display("FAIL wm_freeze got=%b exp=111111", stall); else n_pass++;
        tick();
        n_total++; if (flush !== 1'b1) $display("FAIL wm_flush got=%b exp=1", flush); else n_pass++;
        n_total++; if (new_pc !== 32'h20) $display("FAIL wm_new_pc got=%h exp=00000020", new_pc); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_total++; if (flush !== 1'b0) $display("FAIL wm_extra_flush%0d got=%b exp=0", i, flush); else n_pass++;
        end
        n_total++; if (flush_count !== 16'd3) $display("FAIL wm_fcount got=%0d exp=3", flush_count); else n_pass++;
        n_total++; if (stall_cycles !== 32'd11) $display("FAIL wm_cycles got=%0d exp=11", stall_cycles); else n_pass++;
    endtask

    task automatic test_back_to_back();
        excepttype_i = 32'h8;
        #1;
        n_total++; if (stall !== 6'b111111) $display("FAIL b2b_freeze1 got=%b exp=111111", stall); else n_pass++;
        tick();
        excepttype_i = 32'he;
        cp0_epc_i    = 32'hBFC0_0300;
        #1;
        n_total++; if (flush !== 1'b1) $display("FAIL b2b_flush1 got=%b exp=1", flush); else n_pass++;
        n_total++; if (new_pc !== 32'h20) $display("FAIL b2b_pc1 got=%h exp=00000020", new_pc); else n_pass++;
        n_total++; if (stall !== 6'b000000) $display("FAIL b2b_flush_stall got=%b exp=000000", stall); else n_pass++;
        tick();
        n_total++; if (stall !== 6'b111111) $display("FAIL b2b_freeze2 got=%b exp=111111", stall); else n_pass++;
        n_total++; if (flush !== 1'b0) $display("FAIL b2b_gap got=%b exp=0", flush); else n_pass++;
        tick();
        excepttype_i = 32'h0;
        #1;
        n_total++; if (flush !== 1'b1) $display("FAIL b2b_flush2 got=%b exp=1", flush); else n_pass++;
        n_total++; if (new_pc !== 32'hBFC0_0300) $display("FAIL b2b_pc2 got=%h exp=bfc00300", new_pc); else n_pass++;
        tick();
        n_total++; if (flush !== 1'b0) $display("FAIL b2b_end got=%b exp=0", flush); else n_pass++;
        n_total++; if (flush_count !== 16'd5) $display("FAIL b2b_fcount got=%0d exp=5", flush_count); else n_pass++;
        n_total++; if (stall_cycles !== 32'd13) $display("FAIL b2b_cycles got=%0d exp=13", stall_cycles); else n_pass++;
    endtask

    task automatic test_watchdog();
        rst = 1'b1;
        #1;
        rst = 1'b0;
        n_total++; if (stall_cycles !== 32'h0) $display("FAIL wd_rst_cycles got=%0d exp=0", stall_cycles); else n_pass++;
        stallreq_ex = 1'b1;
        repeat (1023) tick();
        n_total++; if (stall_timeout !== 1'b0) $display("FAIL wd_early got=%b exp=0", stall_timeout); else n_pass++;
        n_total++; if (stall_cycles !== 32'd1023) $display("FAIL wd_cycles1023 got=%0d exp=1023", stall_cycles); else n_pass++;
        tick();
        n_total++; if (stall_timeout !== 1'b1) $display("FAIL wd_hit got=%b exp=1", stall_timeout); else n_pass++;
        n_total++; if (stall_cycles !== 32'd1024) $display("FAIL wd_cycles1024 got=%0d exp=1024", stall_cycles); else n_pass++;
        stallreq_ex = 1'b0;
        repeat (3) tick();
        n_total++; if (stall_timeout !== 1'b1) $display("FAIL wd_sticky got=%b exp=1", stall_timeout); else n_pass++;
        n_total++; if (stall_cycles !== 32'd1024) $display("FAIL wd_cycles_hold got=%0d exp=1024", stall_cycles); else n_pass++;
    endtask

    task automatic test_reset_mid();
        excepttype_i = 32'h8;
        stallreq_mem = 1'b1;
        tick();
        tick();
        n_total++; if (stall !== 6'b011111) $display("FAIL rm_waitmem got=%b exp=011111", stall); else n_pass++;
        rst = 1'b1;
        #1;
        n_total++; if (stall_timeout !== 1'b0) $display("FAIL rm_async_timeout got=%b exp=0", stall_timeout); else n_pass++;
        n_total++; if (stall !== 6'b000000) $display("FAIL rm_async_stall got=%b exp=000000", stall); else n_pass++;
        n_total++; if (flush !== 1'b0) $display("FAIL rm_async_flush got=%b exp=0", flush); else n_pass++;
        n_total++; if (new_pc !== 32'h0) $display("FAIL rm_async_pc got=%h exp=0", new_pc); else n_pass++;
        tick();
        excepttype_i = 32'h0;
        stallreq_mem = 1'b0;
        rst = 1'b0;
        #1;
        n_total++; if (stall !== 6'b000000) $display("FAIL rm_no_pending got=%b exp=000000", stall); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_total++; if (flush !== 1'b0) $display("FAIL rm_flush%0d got=%b exp=0", i, flush); else n_pass++;
        end
        n_total++; if (flush_count !== 16'd0) $display("FAIL rm_fcount got=%0d exp=0", flush_count); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_requests();
        test_exception();
        test_eret();
        test_wait_mem();
        test_back_to_back();
        test_watchdog();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
